keyboard_voice_alloc: RTL and testbench

- Converts PS/2 set-2 make/break events into an 8-voice polyphonic note table for the sound synth.
- Each voice carries a fixed-point frequency (Q12.20 Hz) and a volume (Q12.20, 1.0 = 1<<20). Just-intonation scale rooted at A2 = 110 Hz.
- Sits between the PS/2 decoder and the oscillator bank.

---
 rtl/keyboard_voice_alloc.sv | 157 +++++++++++++++
 tb/tb_keyboard_voice_alloc.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/keyboard_voice_alloc.sv
// Purpose : maps PS/2 set-2 make/break events onto an 8-voice note table (freq + volume, Q12.20).
// Latency : 1 cycle; the edge that samples an event also updates the registered outputs.
// Backpressure: none; one event per clock, a press with no free voice is dropped
//               (or steals the oldest voice when KEYBOARD_VOICE_STEAL_EN is defined).
module keyboard_voice_alloc #(
  parameter int          VOICES    = 8,
  parameter logic [31:0] BASE_FREQ = 32'd115343360,
  parameter logic [31:0] FULL_VOL  = 32'd1048576
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pressed,
  input  logic [7:0]            code,
  output logic [VOICES*32-1:0]  frequencies,
  output logic [VOICES*32-1:0]  voice_volumes
);

  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  // Just-intonation ratios folded to constants at elaboration time.
  localparam logic [31:0] F_1_1   = 32'((64'(BASE_FREQ) * 64'd1)  / 64'd1);
  localparam logic [31:0] F_16_15 = 32'((64'(BASE_FREQ) * 64'd16) / 64'd15);
  localparam logic [31:0] F_9_8   = 32'((64'(BASE_FREQ) * 64'd9)  / 64'd8);
  localparam logic [31:0] F_6_5   = 32'((64'(BASE_FREQ) * 64'd6)  / 64'd5);
  localparam logic [31:0] F_5_4   = 32'((64'(BASE_FREQ) * 64'd5)  / 64'd4);
  localparam logic [31:0] F_4_3   = 32'((64'(BASE_FREQ) * 64'd4)  / 64'd3);
  localparam logic [31:0] F_45_32 = 32'((64'(BASE_FREQ) * 64'd45) / 64'd32);
  localparam logic [31:0] F_3_2   = 32'((64'(BASE_FREQ) * 64'd3)  / 64'd2);
  localparam logic [31:0] F_8_5   = 32'((64'(BASE_FREQ) * 64'd8)  / 64'd5);
  localparam logic [31:0] F_5_3   = 32'((64'(BASE_FREQ) * 64'd5)  / 64'd3);
  localparam logic [31:0] F_9_5   = 32'((64'(BASE_FREQ) * 64'd9)  / 64'd5);
  localparam logic [31:0] F_15_8  = 32'((64'(BASE_FREQ) * 64'd15) / 64'd8);
  localparam logic [31:0] F_2_1   = 32'((64'(BASE_FREQ) * 64'd2)  / 64'd1);

  logic              r_busy [VOICES];
  logic [7:0]        r_code [VOICES];
  logic [31:0]       r_freq [VOICES];
  logic [31:0]       r_vol  [VOICES];

  logic              w_mapped;
  logic [31:0]       w_key_freq;
  logic              w_hit;
  logic              w_free_vld;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_alloc_vld;
  logic [IDX_W-1:0]  w_alloc_idx;

  // Key ROM: scan code to note frequency; unmapped codes are flagged and ignored.
  always_comb begin
    w_mapped   = 1'b1;
    w_key_freq = 32'd0;
    case (code)
      8'h15:   w_key_freq = F_1_1;
      8'h16:   w_key_freq = F_16_15;
      8'h1D:   w_key_freq = F_9_8;
      8'h1E:   w_key_freq = F_6_5;
      8'h24:   w_key_freq = F_5_4;
      8'h2D:   w_key_freq = F_4_3;
      8'h26:   w_key_freq = F_45_32;
      8'h2C:   w_key_freq = F_3_2;
      8'h25:   w_key_freq = F_8_5;
      8'h35:   w_key_freq = F_5_3;
      8'h2E:   w_key_freq = F_9_5;
      8'h3C:   w_key_freq = F_15_8;
      8'h43:   w_key_freq = F_2_1;
      default: w_mapped   = 1'b0;
    endcase
  end

  // Already-held detection and lowest-index free voice search.
  always_comb begin
    w_hit      = 1'b0;
    w_free_vld = 1'b0;
    w_free_idx = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (r_busy[i] && (r_code[i] == code)) w_hit = 1'b1;
      if (!r_busy[i]) begin
        w_free_vld = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

`ifdef KEYBOARD_VOICE_STEAL_EN
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(VOICES - 1);

  logic [IDX_W-1:0]  r_age [VOICES];
  logic [IDX_W-1:0]  w_old_idx;
  logic [IDX_W-1:0]  w_old_age;

  // Oldest voice: strictly-greater scan keeps the lowest index on ties.
  always_comb begin
    w_old_idx = '0;
    w_old_age = r_age[0];
    for (int i = 1; i < VOICES; i++) begin
      if (r_age[i] > w_old_age) begin
        w_old_age = r_age[i];
        w_old_idx = IDX_W'(i);
      end
    end
    w_alloc_vld = 1'b1;
    w_alloc_idx = w_free_vld ? w_free_idx : w_old_idx;
  end

  // Age counters: the allocated voice restarts at 0, all others age (saturating).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < VOICES; i++) r_age[i] <= '0;
    end else if (w_mapped && pressed && !w_hit) begin
      for (int i = 0; i < VOICES; i++) begin
        if (IDX_W'(i) == w_alloc_idx) r_age[i] <= '0;
        else if (r_age[i] != AGE_MAX) r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end
`else
  // Without stealing, a press only lands when some voice is free.
  always_comb begin
    w_alloc_vld = w_free_vld;
    w_alloc_idx = w_free_idx;
  end
`endif

  // Voice table update: allocate on new press, free every matching voice on release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < VOICES; i++) begin
        r_busy[i] <= 1'b0;
        r_code[i] <= 8'd0;
        r_freq[i] <= 32'd0;
        r_vol[i]  <= 32'd0;
      end
    end else if (w_mapped) begin
      if (pressed) begin
        if (!w_hit && w_alloc_vld) begin
          r_busy[w_alloc_idx] <= 1'b1;
          r_code[w_alloc_idx] <= code;
          r_freq[w_alloc_idx] <= w_key_freq;
          r_vol[w_alloc_idx]  <= FULL_VOL;
        end
      end else begin
        for (int i = 0; i < VOICES; i++) begin
          if (r_busy[i] && (r_code[i] == code)) begin
            r_busy[i] <= 1'b0;
            r_vol[i]  <= 32'd0;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_out
    assign frequencies[g*32 +: 32]   = r_freq[g];
    assign voice_volumes[g*32 +: 32] = r_vol[g];
  end

endmodule

// File: tb/tb_keyboard_voice_alloc.sv
// Purpose : scoreboard bench for keyboard_voice_alloc; stimulus pushes expected snapshots, monitor compares.
// Latency : expectation for an event is checked 1ns after the rising edge that samples it.
// Backpressure: none; one event driven per clock on the falling edge.
module tb_keyboard_voice_alloc;
  localparam int V = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             pressed = 1'b0;
  logic [7:0]       code = 8'd0;
  logic [V*32-1:0]  frequencies;
  logic [V*32-1:0]  voice_volumes;

  always #5 clk = ~clk;

  keyboard_voice_alloc dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pressed       (pressed),
    .code          (code),
    .frequencies   (frequencies),
    .voice_volumes (voice_volumes)
  );

  typedef struct packed {
    logic [V*32-1:0] f;
    logic [V*32-1:0] v;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  // Reference note table, values written out by hand.
  bit          m_busy [V];
  logic [7:0]  m_code [V];
  logic [31:0] m_freq [V];
  logic [31:0] m_vol  [V];
  int          m_age  [V];

  function automatic logic [31:0] key_freq(input logic [7:0] c, output bit ok);
    ok = 1'b1;
    case (c)
      8'h15: return 32'd115343360;
      8'h16: return 32'd123032917;
      8'h1D: return 32'd129761280;
      8'h1E: return 32'd138412032;
      8'h24: return 32'd144179200;
      8'h2D: return 32'd153791146;
      8'h26: return 32'd162201600;
      8'h2C: return 32'd173015040;
      8'h25: return 32'd184549376;
      8'h35: return 32'd192238933;
      8'h2E: return 32'd207618048;
      8'h3C: return 32'd216268800;
      8'h43: return 32'd230686720;
      default: begin ok = 1'b0; return 32'd0; end
    endcase
  endfunction

  task automatic model(input bit rst, input bit p, input logic [7:0] c);
    bit          ok;
    bit          hit;
    int          slot;
    logic [31:0] fr;
    if (rst) begin
      for (int i = 0; i < V; i++) begin
        m_busy[i] = 0; m_code[i] = 0; m_freq[i] = 0; m_vol[i] = 0; m_age[i] = 0;
      end
      return;
    end
    fr = key_freq(c, ok);
    if (!ok) return;
    if (!p) begin
      for (int i = 0; i < V; i++)
        if (m_busy[i] && m_code[i] == c) begin m_busy[i] = 0; m_vol[i] = 0; end
      return;
    end
    hit = 0;
    for (int i = 0; i < V; i++) if (m_busy[i] && m_code[i] == c) hit = 1;
    if (hit) return;
    slot = -1;
    for (int i = V - 1; i >= 0; i--) if (!m_busy[i]) slot = i;
`ifdef KEYBOARD_VOICE_STEAL_EN
    if (slot < 0) begin
      slot = 0;
      for (int i = 1; i < V; i++) if (m_age[i] > m_age[slot]) slot = i;
    end
    for (int i = 0; i < V; i++) begin
      if (i == slot) m_age[i] = 0;
      else if (m_age[i] < V - 1) m_age[i] = m_age[i] + 1;
    end
`endif
    if (slot < 0) return;
    m_busy[slot] = 1; m_code[slot] = c; m_freq[slot] = fr; m_vol[slot] = 32'd1048576;
  endtask

  task automatic step(input bit rst, input bit p, input logic [7:0] c, input string nm);
    snap_t s;
    @(negedge clk);
    reset_n = ~rst;
    pressed = p;
    code    = c;
    model(rst, p, c);
    for (int i = 0; i < V; i++) begin
      s.f[i*32 +: 32] = m_freq[i];
      s.v[i*32 +: 32] = m_vol[i];
    end
    exp_q.push_back(s);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are presented every cycle; compare against each queued expectation.
  initial begin
    snap_t s;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        s  = exp_q.pop_front();
        nm = name_q.pop_front();
        for (int i = 0; i < V; i++) begin
          checks++;
          if (frequencies[i*32 +: 32] !== s.f[i*32 +: 32]) begin
            errors++;
            $display("FAIL %s freq[%0d]: got %0d expected %0d", nm, i,
                     frequencies[i*32 +: 32], s.f[i*32 +: 32]);
          end
          checks++;
          if (voice_volumes[i*32 +: 32] !== s.v[i*32 +: 32]) begin
            errors++;
            $display("FAIL %s vol[%0d]: got %0d expected %0d", nm, i,
                     voice_volumes[i*32 +: 32], s.v[i*32 +: 32]);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] keys [8];
    keys[0] = 8'h15; keys[1] = 8'h16; keys[2] = 8'h1D; keys[3] = 8'h1E;
    keys[4] = 8'h24; keys[5] = 8'h2D; keys[6] = 8'h26; keys[7] = 8'h2C;

    step(1, 0, 8'h00, "reset");
    step(0, 0, 8'h00, "idle");
    step(0, 1, 8'h15, "press_h15");
    step(0, 0, 8'h15, "release_h15");
    step(0, 1, 8'h2C, "press_h2C");
    step(0, 1, 8'h16, "press_h16");
    step(0, 0, 8'h2C, "release_h2C");
    step(0, 1, 8'h35, "realloc_h35");
    step(0, 0, 8'h16, "release_h16");
    step(0, 0, 8'h35, "release_h35");
    for (int k = 0; k < 5; k++) step(0, 1, 8'h24, "hold_h24");
    step(0, 0, 8'h24, "release_h24");
    for (int k = 0; k < 8; k++) step(0, 1, keys[k], "fill_voices");
    step(0, 1, 8'h43, "press_h43_full");
    step(0, 1, 8'h1C, "press_unmapped");
    step(0, 0, 8'h35, "release_unheld");
    step(0, 0, 8'h1C, "release_unmapped");
    step(0, 0, 8'h16, "release_h16_full");
    step(0, 1, 8'h25, "press_h25_one_free");
    step(0, 1, 8'h3C, "press_h3C_full");
    step(1, 1, 8'h15, "reset_with_key");
    step(0, 0, 8'h00, "idle_after_reset");
    step(0, 1, 8'h2E, "press_h2E_after_reset");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
